addsub_serial_ctrl: RTL and testbench

Multi-cycle controller that performs N*4-bit add/subtract by sequencing a single 4-bit add/sub nibble datapath, least significant nibble first.
It holds the operands, steers one nibble per cycle through the 4-bit unit, and chains the carry between nibbles.
It reports the wide result with carry and signed overflow, using a start/busy/done handshake.
It sits between the control logic and the 4-bit add/sub stage, which is instantiated internally.

---
 rtl/addsub_serial_ctrl.sv | 151 +++++++++++++++
 tb/tb_addsub_serial_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : addsub_serial_ctrl (with nibble stage addsub_nibble)
// Brief    : Nibble-serial N*4-bit add/subtract controller. Sequences one
//            4-bit add/sub stage LSB nibble first, chains the carry, and
//            reports result, carry and signed overflow with start/busy/done.
// Revision : 1.0  initial release
// ============================================================================

// 4-bit add/sub stage: {cout, s} = a + (b ^ {4{sub}}) + cin
module addsub_nibble (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       sub_i,
   input  logic       cin_i,
   output logic [3:0] s_o,
   output logic       cout_o
);

   logic [4:0] w_sum;

   // Five-bit sum so the nibble carry-out is captured directly
   assign w_sum          = {1'b0, a_i} + {1'b0, b_i ^ {4{sub_i}}} + {4'b0000, cin_i};
   assign {cout_o, s_o}  = w_sum;

endmodule

module addsub_serial_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 addsub,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] result,
   output logic                 carry,
   output logic                 overflow
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic             op_q;
   logic [IDX_W-1:0] idx_q;
   logic             cin_q;
   logic [W-1:0]     result_q;
   logic             carry_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   logic [3:0]       w_a_nib;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_s_nib;
   logic             w_cout;
   logic             w_ovf;

   // Steer the currently indexed nibble of each held operand into the stage
   assign w_a_nib = a_q[{idx_q, 2'b00} +: 4];
   assign w_b_nib = b_q[{idx_q, 2'b00} +: 4];

   addsub_nibble u_nibble (
      .a_i    (w_a_nib),
      .b_i    (w_b_nib),
      .sub_i  (op_q),
      .cin_i  (cin_q),
      .s_o    (w_s_nib),
      .cout_o (w_cout)
   );

   // Overflow from sign bits: the effective B operand is inverted for
   // subtract, so one rule covers both operations. Only meaningful while the
   // top nibble is in the stage, which is the only time it is captured.
   assign w_ovf = (a_q[W-1] == (b_q[W-1] ^ op_q)) && (w_s_nib[3] != a_q[W-1]);

   // Sequencer: accept, process one nibble per edge, pulse done, return idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 1'b0;
         idx_q    <= '0;
         cin_q    <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= addsub;
                  idx_q   <= '0;
                  // Subtract is A + ~B + 1: the +1 enters as the first carry
                  cin_q   <= addsub;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               result_q[{idx_q, 2'b00} +: 4] <= w_s_nib;
               cin_q <= w_cout;
               idx_q <= idx_q + 1'b1;
               if (idx_q == C_LAST_IDX) begin
                  carry_q <= w_cout;
                  ovf_q   <= w_ovf;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_serial_ctrl
// Brief    : Self-checking bench for addsub_serial_ctrl (NIBBLES=4 and 2).
//            Expected values come from a plain-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_addsub_serial_ctrl;

   logic        clk;
   logic        rst_n;

   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        addsub;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        carry;
   logic        overflow;

   logic        start2;
   logic [7:0]  a2;
   logic [7:0]  b2;
   logic        addsub2;
   logic        busy2;
   logic        done2;
   logic [7:0]  result2;
   logic        carry2;
   logic        overflow2;

   int tests = 0;
   int fails = 0;

   addsub_serial_ctrl #(.NIBBLES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .addsub(addsub),
      .busy(busy), .done(done), .result(result), .carry(carry), .overflow(overflow)
   );

   addsub_serial_ctrl #(.NIBBLES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .addsub(addsub2),
      .busy(busy2), .done(done2), .result(result2), .carry(carry2), .overflow(overflow2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: W-bit wrap result, unsigned carry/no-borrow, signed overflow
   task automatic model(input longint unsigned ta, input longint unsigned tb_, input bit op,
                        input int w, output logic [63:0] r, output logic c, output logic v);
      longint unsigned m;
      longint sa, sb, sr, smax, smin;
      m    = (64'd1 << w) - 64'd1;
      smax = (64'sd1 <<< (w - 1)) - 64'sd1;
      smin = -(64'sd1 <<< (w - 1));
      sa   = (ta > longint'(smax)) ? longint'(ta) - (64'sd1 <<< w) : longint'(ta);
      sb   = (tb_ > longint'(smax)) ? longint'(tb_) - (64'sd1 <<< w) : longint'(tb_);
      if (!op) begin
         r  = (ta + tb_) & m;
         c  = ((ta + tb_) > m);
         sr = sa + sb;
      end else begin
         r  = (ta - tb_) & m;
         c  = (ta >= tb_);
         sr = sa - sb;
      end
      v = (sr > smax) || (sr < smin);
   endtask

   // Run one 16-bit op. Called at a negedge; start is presented immediately.
   // inject=1 keeps start asserted with junk operands throughout RUN and DONE.
   task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input bit op,
                        input bit inject, input string tag);
      logic [63:0] er;
      logic        ec, ev;
      int          edges;
      model(64'(ta), 64'(tb_), op, 16, er, ec, ev);
      start = 1'b1; a = ta; b = tb_; addsub = op;
      @(negedge clk);
      check({tag, " busy_run"}, 64'(busy), 64'd1);
      start = inject; a = 16'($urandom); b = 16'($urandom); addsub = 1'($urandom);
      edges = 0;
      while (done !== 1'b1 && edges < 20) begin
         @(negedge clk);
         edges++;
         start = inject; a = 16'($urandom); b = 16'($urandom); addsub = 1'($urandom);
      end
      check({tag, " latency"}, 64'(edges), 64'd4);
      check({tag, " result"},  64'(result), er);
      check({tag, " carry"},   64'(carry), 64'(ec));
      check({tag, " ovf"},     64'(overflow), 64'(ev));
      check({tag, " busy_done"}, 64'(busy), 64'd1);
      @(negedge clk);
      start = 1'b0;
      check({tag, " done_pulse"}, 64'(done), 64'd0);
      check({tag, " busy_fall"},  64'(busy), 64'd0);
      check({tag, " hold"},       64'({carry, overflow, result}), 64'({ec, ev, er[15:0]}));
      if (inject) begin
         for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check({tag, " no_requeue"}, 64'({busy, done}), 64'd0);
         end
      end
   endtask

   task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input bit op, input string tag);
      logic [63:0] er;
      logic        ec, ev;
      int          edges;
      model(64'(ta), 64'(tb_), op, 8, er, ec, ev);
      start2 = 1'b1; a2 = ta; b2 = tb_; addsub2 = op;
      @(negedge clk);
      start2 = 1'b0; a2 = 8'($urandom); b2 = 8'($urandom);
      edges = 0;
      while (done2 !== 1'b1 && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      check({tag, " latency"}, 64'(edges), 64'd2);
      check({tag, " result"},  64'(result2), er);
      check({tag, " carry"},   64'(carry2), 64'(ec));
      check({tag, " ovf"},     64'(overflow2), 64'(ev));
      @(negedge clk);
      check({tag, " end"}, 64'({busy2, done2}), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0; a = '0; b = '0; addsub = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; addsub2 = 1'b0;
      repeat (2) @(negedge clk);

      check("reset_state16", 64'({busy, done, carry, overflow, result}), 64'd0);
      check("reset_state8",  64'({busy2, done2, carry2, overflow2, result2}), 64'd0);

      // Release and present start for the very first edge
      rst_n = 1'b1;
      run16(16'h1234, 16'h0FFF, 1'b0, 1'b0, "add_basic");
      run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_carry");
      run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
      run16(16'h0005, 16'h0007, 1'b1, 1'b0, "sub_borrow");
      run16(16'h1234, 16'h1234, 1'b1, 1'b0, "sub_equal");
      run16(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_ovf");

      // Abort mid-operation after two RUN edges
      start = 1'b1; a = 16'h1234; b = 16'h1111; addsub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_clear", 64'({busy, done, carry, overflow, result}), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", 64'(done), 64'd0);
      end
      rst_n = 1'b1;
      run16(16'h0003, 16'h0004, 1'b0, 1'b0, "after_abort");

      // Extra starts during RUN/DONE ignored; restart right when idle
      run16(16'h0001, 16'h0001, 1'b0, 1'b1, "hs_ignore");
      run16(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "hs_restart");

      // Randomized operations, back to back
      for (int i = 0; i < 24; i++) begin
         run16(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rand16");
      end

      // Narrow instance
      run8(8'h7F, 8'h01, 1'b0, "n2_ovf");
      run8(8'h80, 8'h01, 1'b1, "n2_sub_ovf");
      for (int i = 0; i < 12; i++) begin
         run8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
